// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: frames an SD SPI-mode command (index + argument + CRC byte),
// pushes it byte-by-byte through spi_controller, polls for R1 with 0xFF bytes,
// then clocks one trailing 0xFF with the card deselected.
// Optional feature macro: SD_CRC7_EN (computed CRC7 instead of fixed CRC byte).
module sd_cmd_engine #(
   parameter int unsigned MAX_POLL = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   output logic        busy,
   output logic        done,
   output logic [7:0]  r1,
   output logic        timeout,
   output logic        cs_n,
   output logic        spi_execute,
   output logic [7:0]  spi_out_word,
   input  logic [7:0]  spi_in_word,
   input  logic        spi_finished
);

   localparam int unsigned IDX_W  = 6;
   localparam int unsigned ARG_W  = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned POLL_W = 8;

   typedef enum logic [2:0] {IDLE, SEND, POLL, TRAIL, FIN} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
   logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d, poll_inc;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [ARG_W-1:0]    arg_q, arg_d;
   logic [BYTE_W-1:0]   r1_d, word_d;
   logic                timeout_d, busy_d, done_d, cs_n_d, exec_d;

`ifdef SD_CRC7_EN
   // Bit-serial CRC7 (x^7+x^3+1, init 0) over the first five frame bytes, MSB first.
   function automatic logic [6:0] crc7(input logic [39:0] data);
      logic [6:0] crc;
      logic       fb;
      crc = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb  = data[i] ^ crc[6];
         crc = {crc[5:0], 1'b0};
         if (fb) crc = crc ^ 7'h09;
      end
      return crc;
   endfunction
`endif

   // Final frame byte: CRC in bits [7:1], end bit set.
   function automatic logic [BYTE_W-1:0] crc_byte(input logic [IDX_W-1:0] idx,
                                                  input logic [ARG_W-1:0] arg);
`ifdef SD_CRC7_EN
      return {crc7({2'b01, idx, arg}), 1'b1};
`else
      logic [ARG_W-1:0] unused_arg;
      unused_arg = arg;
      if (idx == IDX_W'(0))      return 8'h95;
      else if (idx == IDX_W'(8)) return 8'h87;
      else                       return 8'h01;
`endif
   endfunction

   // Frame byte n of the 6-byte command frame.
   function automatic logic [BYTE_W-1:0] frame_byte(input logic [IDX_W-1:0] idx,
                                                    input logic [ARG_W-1:0] arg,
                                                    input logic [CNT_W-1:0] n);
      case (n)
         3'd0:    return {2'b01, idx};
         3'd1:    return arg[31:24];
         3'd2:    return arg[23:16];
         3'd3:    return arg[15:8];
         3'd4:    return arg[7:0];
         default: return crc_byte(idx, arg);
      endcase
   endfunction

   // State, counters, captured command and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         byte_cnt_q   <= '0;
         poll_cnt_q   <= '0;
         idx_q        <= '0;
         arg_q        <= '0;
         r1           <= 8'hFF;
         timeout      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cs_n         <= 1'b1;
         spi_execute  <= 1'b0;
         spi_out_word <= 8'hFF;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         poll_cnt_q   <= poll_cnt_d;
         idx_q        <= idx_d;
         arg_q        <= arg_d;
         r1           <= r1_d;
         timeout      <= timeout_d;
         busy         <= busy_d;
         done         <= done_d;
         cs_n         <= cs_n_d;
         spi_execute  <= exec_d;
         spi_out_word <= word_d;
      end
   end

   // Next-state and next-output logic; each spi_finished immediately schedules the next byte.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      poll_cnt_d = poll_cnt_q;
      idx_d      = idx_q;
      arg_d      = arg_q;
      r1_d       = r1;
      timeout_d  = timeout;
      busy_d     = busy;
      done_d     = 1'b0;
      cs_n_d     = cs_n;
      exec_d     = 1'b0;
      word_d     = spi_out_word;
      poll_inc   = poll_cnt_q + POLL_W'(1);

      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d      = cmd_index;
               arg_d      = cmd_arg;
               timeout_d  = 1'b0;
               byte_cnt_d = '0;
               poll_cnt_d = '0;
               busy_d     = 1'b1;
               cs_n_d     = 1'b0;
               exec_d     = 1'b1;
               word_d     = frame_byte(cmd_index, cmd_arg, CNT_W'(0));
               state_d    = SEND;
            end
         end
         SEND: begin
            if (spi_finished) begin
               exec_d = 1'b1;
               if (byte_cnt_q == CNT_W'(5)) begin
                  word_d  = 8'hFF;
                  state_d = POLL;
               end else begin
                  byte_cnt_d = byte_cnt_q + CNT_W'(1);
                  word_d     = frame_byte(idx_q, arg_q, byte_cnt_q + CNT_W'(1));
               end
            end
         end
         POLL: begin
            if (spi_finished) begin
               poll_cnt_d = poll_inc;
               exec_d     = 1'b1;
               word_d     = 8'hFF;
               if (!spi_in_word[7]) begin
                  r1_d    = spi_in_word;
                  cs_n_d  = 1'b1;
                  state_d = TRAIL;
               end else if (poll_inc == POLL_W'(MAX_POLL)) begin
                  r1_d      = 8'hFF;
                  timeout_d = 1'b1;
                  cs_n_d    = 1'b1;
                  state_d   = TRAIL;
               end
            end
         end
         TRAIL: begin
            if (spi_finished) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Testbench for sd_cmd_engine: card/spi_controller model with random latency,
// table-driven command vectors, random commands against a frame-level model,
// and hand sequences for reset, ignored starts and back-to-back commands.
module tb_sd_cmd_engine;

   localparam int unsigned MAX_POLL = 8;

   logic        clk, rst_n, start, busy, done, timeout, cs_n, spi_execute, spi_finished;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [7:0]  r1, spi_out_word, spi_in_word;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   bit chk_en   = 1'b0;
   bit trail_seen = 1'b0;

   logic [7:0] tx_q[$];
   bit         cs_q[$];
   int         nff_g = 0;
   logic [7:0] resp_g = 8'h01;

   sd_cmd_engine #(.MAX_POLL(MAX_POLL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
      .busy(busy), .done(done), .r1(r1), .timeout(timeout), .cs_n(cs_n),
      .spi_execute(spi_execute), .spi_out_word(spi_out_word),
      .spi_in_word(spi_in_word), .spi_finished(spi_finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference CRC byte: polynomial long division of frame*x^7 by 0x89.
   function automatic logic [7:0] m_byte5(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CRC7_EN
      logic [46:0] v;
      v = {2'b01, idx, arg, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
      return {v[6:0], 1'b1};
`else
      logic [31:0] a;
      a = arg;
      if (a == 32'hDEAD_0000 && idx == 6'd63) return 8'h01;
      return (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'h01;
`endif
   endfunction

   // Card response to transfer k of the current transaction.
   function automatic logic [7:0] card_resp(input int k);
      if (k < 6) return 8'($urandom);
      if (k - 6 < nff_g) return 8'hFF;
      return resp_g;
   endfunction

   // spi_controller + card model: records each issued byte, answers after 1..3 cycles.
   initial begin
      int  k, lat;
      bit  trail;
      spi_finished = 1'b0;
      spi_in_word  = 8'hFF;
      @(negedge clk);
      forever begin
         if (rst_n && spi_execute) begin
            k = tx_q.size();
            tx_q.push_back(spi_out_word);
            cs_q.push_back(cs_n);
            trail = cs_n;
            lat = $urandom_range(1, 3);
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               check("exec_while_outstanding", 32'(spi_execute), 32'd0);
            end
            spi_in_word  = card_resp(k);
            spi_finished = 1'b1;
            @(negedge clk);
            spi_finished = 1'b0;
            spi_in_word  = 8'hFF;
            if (!trail && chk_en && rst_n)
               check("exec_after_finished", 32'(spi_execute), 32'd1);
         end else begin
            @(negedge clk);
         end
      end
   end

   // Done counter and chip-select continuity monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (!busy) trail_seen = 1'b0;
         else begin
            if (spi_execute && cs_n) trail_seen = 1'b1;
            if (chk_en) check("cs_low_while_busy", 32'(cs_n), 32'(trail_seen));
         end
      end
   end

   // One full command; returns in the done cycle.
   task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input int nff,
                          input logic [7:0] resp, input logic [7:0] exp_r1, input bit exp_to,
                          input bit glitch);
      logic [47:0] frame;
      logic [7:0]  exp_q[$];
      bit          exp_cs[$];
      int          npoll, bad;
      bit          got, glitched;
      nff_g  = nff;
      resp_g = resp;
      @(negedge clk);
      tx_q.delete();
      cs_q.delete();
      start = 1'b1; cmd_index = idx; cmd_arg = arg;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("timeout_cleared", 32'(timeout), 32'd0);
      got = 1'b0; glitched = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (glitch && !glitched && tx_q.size() == 2) begin
            start = 1'b1; cmd_index = ~idx; cmd_arg = ~arg; glitched = 1'b1;
         end else start = 1'b0;
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      start = 1'b0;
      check("done_seen", 32'(got), 32'd1);
      check("r1_at_done", 32'(r1), 32'(exp_r1));
      check("timeout_at_done", 32'(timeout), 32'(exp_to));
      check("busy_at_done", 32'(busy), 32'd0);
      frame = {2'b01, idx, arg, m_byte5(idx, arg)};
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(frame[47 - 8*i -: 8]);
         exp_cs.push_back(1'b0);
      end
      npoll = (nff < int'(MAX_POLL)) ? nff + 1 : int'(MAX_POLL);
      for (int i = 0; i < npoll; i++) begin
         exp_q.push_back(8'hFF);
         exp_cs.push_back(1'b0);
      end
      exp_q.push_back(8'hFF);
      exp_cs.push_back(1'b1);
      check("tx_count", 32'(tx_q.size()), 32'(exp_q.size()));
      if (tx_q.size() == exp_q.size()) begin
         bad = -1;
         for (int i = 0; i < exp_q.size(); i++)
            if (tx_q[i] !== exp_q[i] || cs_q[i] !== exp_cs[i]) begin bad = i; break; end
         if (bad >= 0)
            check($sformatf("tx_byte%0d_cs_and_data", bad), {23'd0, cs_q[bad], tx_q[bad]},
                  {23'd0, exp_cs[bad], exp_q[bad]});
         else check("tx_stream", 32'd0, 32'(bad + 1));
      end
   endtask

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
      int          nff;
      logic [7:0]  resp;
      logic [7:0]  exp_r1;
      bit          exp_to;
      bit          chk_b5;
      logic [7:0]  exp_b5;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [5:0]  ridx;
      logic [31:0] rarg;
      int          rnff;
      logic [7:0]  rresp;
      int          cnt;
      vecs[0] = '{6'd0,  32'h0000_0000, 1,  8'h01, 8'h01, 1'b0, 1'b1, 8'h95};
      vecs[1] = '{6'd8,  32'h0000_01AA, 0,  8'h01, 8'h01, 1'b0, 1'b1, 8'h87};
`ifdef SD_CRC7_EN
      vecs[2] = '{6'd55, 32'h0000_0000, 2,  8'h01, 8'h01, 1'b0, 1'b1, 8'h65};
`else
      vecs[2] = '{6'd55, 32'h0000_0000, 2,  8'h01, 8'h01, 1'b0, 1'b1, 8'h01};
`endif
      vecs[3] = '{6'd17, 32'h1234_5678, 8,  8'h00, 8'hFF, 1'b1, 1'b0, 8'h00};
      vecs[4] = '{6'd41, 32'h4000_0000, 7,  8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
      vecs[5] = '{6'd63, 32'hFFFF_FFFF, 30, 8'h05, 8'hFF, 1'b1, 1'b0, 8'h00};

      rst_n = 1'b0; start = 1'b0; cmd_index = '0; cmd_arg = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_r1", 32'(r1), 32'hFF);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_exec", 32'(spi_execute), 32'd0);
      check("rst_word", 32'(spi_out_word), 32'hFF);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Table vectors.
      foreach (vecs[i]) begin
         run_txn(vecs[i].idx, vecs[i].arg, vecs[i].nff, vecs[i].resp,
                 vecs[i].exp_r1, vecs[i].exp_to, 1'b0);
         if (vecs[i].chk_b5 && tx_q.size() > 5)
            check($sformatf("vec%0d_byte5", i), 32'(tx_q[5]), 32'(vecs[i].exp_b5));
      end

      // Random commands against the model.
      for (int n = 0; n < 15; n++) begin
         ridx  = 6'($urandom);
         rarg  = $urandom;
         rnff  = $urandom_range(0, 11);
         rresp = 8'($urandom) & 8'h7F;
         run_txn(ridx, rarg, rnff, rresp,
                 (rnff < int'(MAX_POLL)) ? rresp : 8'hFF, rnff >= int'(MAX_POLL), 1'b0);
      end

      // Start during SEND is ignored; exactly one done.
      done_cnt = 0;
      run_txn(6'd12, 32'hA5A5_0F0F, 1, 8'h00, 8'h00, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      check("glitch_single_done", 32'(done_cnt), 32'd1);
      check("glitch_idle_after", 32'(busy), 32'd0);

      // Start in the FIN cycle is ignored.
      run_txn(6'd9, 32'h0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
      start = 1'b1; cmd_index = 6'd1;
      @(negedge clk);
      start = 1'b0;
      check("fin_start_busy", 32'(busy), 32'd0);
      check("fin_start_cs_n", 32'(cs_n), 32'd1);
      repeat (2) @(negedge clk);

      // Back-to-back: timeout command, then a start in the cycle after done.
      run_txn(6'd2, 32'h1, 40, 8'h00, 8'hFF, 1'b1, 1'b0);
      run_txn(6'd8, 32'h0000_01AA, 3, 8'h01, 8'h01, 1'b0, 1'b0);

      // Asynchronous reset during the third frame byte.
      chk_en = 1'b0;
      done_cnt = 0;
      nff_g = 1; resp_g = 8'h01;
      @(negedge clk);
      tx_q.delete(); cs_q.delete();
      start = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h0000_01AA;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (tx_q.size() < 3 && cnt < 200) begin
         @(negedge clk); #1;
         cnt++;
      end
      check("reset_reached_byte3", 32'(tx_q.size()), 32'd3);
      rst_n = 1'b0;
      #1;
      check("arst_cs_n", 32'(cs_n), 32'd1);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_exec", 32'(spi_execute), 32'd0);
      check("arst_r1", 32'(r1), 32'hFF);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("arst_no_done", 32'(done_cnt), 32'd0);
      chk_en = 1'b1;
      run_txn(6'd0, 32'h0, 1, 8'h01, 8'h01, 1'b0, 1'b0);
      if (tx_q.size() > 5) check("post_reset_byte5", 32'(tx_q[5]), 32'h95);

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
- Command-framing stage directly upstream of spi_controller.
- Accepts an SD command (6-bit index, 32-bit argument) and serialises the 6-byte SPI-mode frame into spi_controller one byte per execute/finished handshake.
- Polls with 0xFF bytes until a valid R1 response arrives or a poll limit expires, then sends one trailing 0xFF with chip select released.
- Drives the card chip select.

Parameters:
- MAX_POLL, 8, maximum number of 0xFF poll bytes sent after the frame while waiting for R1 (legal range 1..255).

Ports:
- clk  in  1  system clock; same clock as spi_controller.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- cmd_index  in  6  SD command number; captured on accepted start.
- cmd_arg  in  32  command argument; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of transaction.
- r1  out  8  captured R1 byte; valid from done until the next accepted start.
- timeout  out  1  set with done if no R1 was seen; cleared on the next accepted start.
- cs_n  out  1  card chip select, active low.
- spi_execute  out  1  one-cycle byte-transfer request to spi_controller.
- spi_out_word  out  8  byte to transmit; held stable from spi_execute until spi_finished.
- spi_in_word  in  8  byte received by spi_controller; valid in the spi_finished cycle.
- spi_finished  in  1  one-cycle pulse: byte transfer complete.

Behaviour:
- Reset values: busy=0, done=0, r1=8'hFF, timeout=0, cs_n=1, spi_execute=0, spi_out_word=8'hFF, state=IDLE, counters=0.
- Reset mid-transaction aborts immediately to these values. No done pulse is produced.
- States: IDLE, SEND, POLL, TRAIL, FIN.
- IDLE:
  - On start=1, latch cmd_index and cmd_arg, clear timeout, go to SEND with byte counter 0.
  - Next cycle: busy=1, cs_n=0, spi_execute=1, spi_out_word=frame byte 0.
- Frame bytes, in order:
  - byte 0 = {2'b01, cmd_index}
  - bytes 1..4 = cmd_arg[31:24], [23:16], [15:8], [7:0]
  - byte 5 = {crc7, 1'b1}
- Issue rule (all states): spi_execute is asserted exactly one cycle, in the cycle after the previous spi_finished (or after entry). No execute is issued while a transfer is outstanding.
- SEND: on spi_finished for byte 5, go to POLL. Received bytes during SEND are ignored.
- POLL:
  - Each transfer sends 8'hFF. Poll counter increments on each spi_finished.
  - If spi_in_word[7]==0, capture r1=spi_in_word and go to TRAIL.
  - Else, if the counter reaches MAX_POLL, set r1=8'hFF and timeout=1, then go to TRAIL.
- TRAIL:
  - cs_n=1 in the same cycle as spi_execute; send 8'hFF (eight clocks with card deselected).
  - On spi_finished go to FIN.
- FIN: done=1 and busy=0 for one cycle, then IDLE. A start asserted in the FIN cycle is ignored.
- start asserted while busy is ignored; captured command fields do not change.
- cs_n stays low continuously from the first execute through the last POLL byte.
- A spi_finished received in IDLE or FIN is ignored.

Optional Feature:
- SD_CRC7_EN defined:
  - crc7 is computed over frame bytes 0..4, MSB first, polynomial x^7+x^3+1, initial value 0.
  - Computed bit-serially or bytewise; must be ready before byte 5 is issued, adding no extra cycles.
- SD_CRC7_EN undefined: fixed CRC byte 5:
  - cmd_index==0 gives 8'h95.
  - cmd_index==8 gives 8'h87.
  - all other commands give 8'h01 (SPI-mode CRC off).

Test Plan:
- CMD0, arg 0, card model returns 0xFF then 0x01:
  - bytes out: 40 00 00 00 00 95, then FF FF, then trailing FF with cs_n=1.
  - r1=0x01, timeout=0, done pulses once.
- CMD8, arg 0x000001AA, both macro settings: byte 5=0x87 and frame 48 00 00 01 AA 87. Under SD_CRC7_EN also check CMD55 arg 0 gives byte 5=0x65.
- MAX_POLL=8, card always returns 0xFF: exactly 8 poll bytes, then trailing FF; r1=0xFF, timeout=1, done=1.
- start pulsed again during SEND with a different cmd_index: ignored; frame unchanged; a single done.
- rst_n low during the third frame byte: cs_n=1, busy=0, spi_execute=0 asynchronously. A fresh start afterwards yields a correct full frame.
- Back-to-back commands (start in the cycle after done): second frame starts; timeout from the previous transaction is cleared.
